quad_input_filter: RTL and testbench

Input conditioning stage for the rotary encoder: takes the raw, asynchronous mechanical quadrature contacts, synchronises them into the `clk` domain, and rejects bounce and glitches. It drives clean, stable `A`/`B` levels straight into the `encoder` block's `A`/`B` inputs. It also flags illegal double transitions, where both channels change in the same cycle, which the downstream counter cannot interpret.

---
 rtl/quad_input_filter.sv | 81 ++++++++
 tb/tb_quad_input_filter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - quadrature contact synchroniser, debounce filter and dual-change detector
// Each channel is re-timed, then must hold a new level for FILTER_CYCLES cycles before it is accepted.
module quad_input_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic A_raw,
  input  logic B_raw,
  input  logic err_clr,
  output logic A,
  output logic B,
  output logic step,
  output logic err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [CNT_W-1:0]       cnt_a;
  logic [CNT_W-1:0]       cnt_b;
  logic                   sA;
  logic                   sB;
  logic                   qual_a;
  logic                   qual_b;

  assign sA = sync_a[SYNC_STAGES-1];
  assign sB = sync_b[SYNC_STAGES-1];

  // A channel qualifies on the last cycle of an uninterrupted run of the new level.
  assign qual_a = (sA != A) && (cnt_a == LAST);
  assign qual_b = (sB != B) && (cnt_b == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
      cnt_a  <= '0;
      cnt_b  <= '0;
      A      <= 1'b0;
      B      <= 1'b0;
      step   <= 1'b0;
      err    <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], A_raw};
      sync_b <= {sync_b[SYNC_STAGES-2:0], B_raw};

      if (sA == A) begin
        cnt_a <= '0;
      end else if (qual_a) begin
        cnt_a <= '0;
        A     <= sA;
      end else begin
        cnt_a <= cnt_a + ONE;
      end

      if (sB == B) begin
        cnt_b <= '0;
      end else if (qual_b) begin
        cnt_b <= '0;
        B     <= sB;
      end else begin
        cnt_b <= cnt_b + ONE;
      end

      step <= qual_a ^ qual_b;

      // Setting takes priority over a simultaneous clear so no dual change is ever lost.
      if (qual_a && qual_b) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_input_filter.sv
// tb/tb_quad_input_filter.sv - scoreboard bench for quad_input_filter
// Expected output changes are queued with their edge number; a monitor pops one per observed change.
module tb_quad_input_filter;

  logic clk = 1'b0;
  logic reset_n, A_raw, B_raw, err_clr;
  logic A, B, step, err;

  quad_input_filter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A_raw   (A_raw),
    .B_raw   (B_raw),
    .err_clr (err_clr),
    .A       (A),
    .B       (B),
    .step    (step),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic [3:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic rst_q;
  logic [3:0] prev = 4'b0000;
  logic [3:0] cur;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset_n;
  end

  // Monitor: outputs are sampled on the falling edge, after edge number cyc.
  always @(negedge clk) begin
    exp_t e;
    cur = {A, B, step, err};
    if (rst_q === 1'b0) begin
      checks++;
      if (cur !== 4'b0000) begin
        fails++;
        $display("FAIL reset_outputs edge=%0d got={A,B,step,err}=%b want=0000", cyc, cur);
      end
    end
    if (cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change edge=%0d got=%b want=no change (was %b)", cyc, cur, prev);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || cur !== e.val) begin
          fails++;
          $display("FAIL output_change edge=%0d got={A,B,step,err}=%b want edge=%0d value=%b",
                   cyc, cur, e.cyc, e.val);
        end
      end
    end
    prev = cur;
  end

  task automatic expect_at(input int c, input logic a, input logic b, input logic s, input logic e);
    exp_t x;
    x.cyc = c;
    x.val = {a, b, s, e};
    q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_err(input logic a, input logic b);
    expect_at(cyc + 1, a, b, 1'b0, 1'b0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(3);
  endtask

  initial begin
    int e;
    logic [8:0] pat;
    reset_n = 1'b0;
    A_raw   = 1'b1;
    B_raw   = 1'b1;
    err_clr = 1'b0;

    // Reset with both raws high, then both accepted together after release.
    tick(3);
    reset_n = 1'b1;
    expect_at(cyc + 6, 1, 1, 0, 1);
    tick(10);
    clear_err(1'b1, 1'b1);

    // Return to A=B=0 one channel at a time.
    A_raw = 1'b0;
    expect_at(cyc + 6, 0, 1, 1, 0);
    expect_at(cyc + 7, 0, 1, 0, 0);
    tick(10);
    B_raw = 1'b0;
    expect_at(cyc + 6, 0, 0, 1, 0);
    expect_at(cyc + 7, 0, 0, 0, 0);
    tick(10);

    // Clean single-channel changes.
    A_raw = 1'b1;
    expect_at(cyc + 6, 1, 0, 1, 0);
    expect_at(cyc + 7, 1, 0, 0, 0);
    tick(10);
    B_raw = 1'b1;
    expect_at(cyc + 6, 1, 1, 1, 0);
    expect_at(cyc + 7, 1, 1, 0, 0);
    tick(10);
    A_raw = 1'b0;
    expect_at(cyc + 6, 0, 1, 1, 0);
    expect_at(cyc + 7, 0, 1, 0, 0);
    tick(10);
    B_raw = 1'b0;
    expect_at(cyc + 6, 0, 0, 1, 0);
    expect_at(cyc + 7, 0, 0, 0, 0);
    tick(10);

    // Three-cycle glitch is rejected.
    A_raw = 1'b1;
    tick(3);
    A_raw = 1'b0;
    tick(10);

    // Four-cycle pulse passes through as a four-cycle pulse.
    e = cyc;
    expect_at(e + 6, 1, 0, 1, 0);
    expect_at(e + 7, 1, 0, 0, 0);
    expect_at(e + 10, 0, 0, 1, 0);
    expect_at(e + 11, 0, 0, 0, 0);
    A_raw = 1'b1;
    tick(4);
    A_raw = 1'b0;
    tick(12);

    // Bounce 1,0,1,1,0,1,1,1,1 then hold high.
    e = cyc;
    pat = 9'b111101101;
    expect_at(e + 11, 1, 0, 1, 0);
    expect_at(e + 12, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      A_raw = pat[k];
      tick(1);
    end
    tick(10);
    A_raw = 1'b0;
    expect_at(cyc + 6, 0, 0, 1, 0);
    expect_at(cyc + 7, 0, 0, 0, 0);
    tick(10);

    // Illegal dual jump, clear, then dual jump coinciding with err_clr.
    A_raw = 1'b1;
    B_raw = 1'b1;
    expect_at(cyc + 6, 1, 1, 0, 1);
    tick(10);
    clear_err(1'b1, 1'b1);
    e = cyc;
    A_raw = 1'b0;
    B_raw = 1'b0;
    expect_at(e + 6, 0, 0, 0, 1);
    tick(5);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(5);
    clear_err(1'b0, 1'b0);

    // Reset at edge 4 of a pending qualification restarts it.
    e = cyc;
    A_raw = 1'b1;
    expect_at(e + 10, 1, 0, 1, 0);
    expect_at(e + 11, 1, 0, 0, 0);
    tick(3);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(12);
    A_raw = 1'b0;
    expect_at(cyc + 6, 0, 0, 1, 0);
    expect_at(cyc + 7, 0, 0, 0, 0);
    tick(12);

    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations got=%0d outstanding want=0 (next edge=%0d)",
               q.size(), q[0].cyc);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
